rr_arbiter_83: RTL and testbench

Round-robin arbiter that shares a single downstream resource among eight requesters and drives both a one-hot grant vector and its 3-bit encoded index. It sits in front of the 8-to-3 encoder datapath as the sequencing stage. It guarantees that the one-hot vector presented to the encoder always has at most one bit set, so the encoded index is never ambiguous. It adds fairness, a bounded hold time and a one-cycle turnaround between owners.

---
 rtl/rr_arbiter_83.sv | 89 ++++++++
 tb/tb_rr_arbiter_83.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_83.sv
// rtl/rr_arbiter_83.sv - eight-way round-robin arbiter with bounded hold and one-cycle turnaround
module rr_arbiter_83 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic       HOLD_ON  = (MAX_HOLD != 0);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] cnt;
  logic       found;
  logic [2:0] win;
  logic [2:0] cand;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    cand  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= 8'd0;
      gnt     <= 8'd0;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          if (!req[gnt_idx] || (HOLD_ON && cnt == HOLD_LIM)) begin
            state   <= RELEASE;
            timeout <= req[gnt_idx];
            cnt     <= 8'd0;
            gnt     <= 8'd0;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          // IDLE and RELEASE share the selection; RELEASE only lasts one cycle.
          timeout <= 1'b0;
          if (en && found) begin
            state   <= GRANT;
            gnt     <= 8'b1 << win;
            gnt_idx <= win;
            gnt_vld <= 1'b1;
            cnt     <= 8'd1;
            ptr     <= win + 3'd1;
          end else begin
            state   <= IDLE;
            gnt     <= 8'd0;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_83.sv
// tb/tb_rr_arbiter_83.sv - bench for rr_arbiter_83 with MAX_HOLD 16 and 4 instances
module tb_rr_arbiter_83;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int n_chk;
  int n_fail;

  rr_arbiter_83 #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
  );

  rr_arbiter_83 #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: who owns the resource, how long, and where the search starts.
  typedef struct {
    int   own;
    int   ptr;
    int   held;
    logic to;
  } mst_t;

  mst_t m[2];
  int   mh[2] = '{16, 4};

  function automatic mst_t m_next(mst_t s, int hold, logic e, logic [7:0] r);
    mst_t n;
    logic done;
    int   c;
    n    = s;
    n.to = 1'b0;
    done = 1'b0;
    if (s.own >= 0) begin
      if (!r[s.own]) begin
        n.own = -1;
      end else if (hold != 0 && s.held == hold) begin
        n.own = -1;
        n.to  = 1'b1;
      end else if (s.held < 255) begin
        n.held = s.held + 1;
      end
    end else if (e) begin
      for (int j = 0; j < 8; j++) begin
        c = (s.ptr + j) % 8;
        if (!done && r[c]) begin
          done   = 1'b1;
          n.own  = c;
          n.held = 1;
          n.ptr  = (c + 1) % 8;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) m[k] <= '{-1, 0, 0, 1'b0};
      else        m[k] <= m_next(m[k], mh[k], en, req);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] dg [2];
  logic [2:0] di [2];
  logic       dv [2];
  logic       dt [2];
  assign dg[0] = gnt_a; assign dg[1] = gnt_b;
  assign di[0] = idx_a; assign di[1] = idx_b;
  assign dv[0] = vld_a; assign dv[1] = vld_b;
  assign dt[0] = to_a;  assign dt[1] = to_b;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] eg;
      logic [2:0] ei;
      eg = (m[k].own >= 0) ? (8'b1 << m[k].own) : 8'd0;
      ei = (m[k].own >= 0) ? 3'(m[k].own) : 3'd0;
      chk($sformatf("model_gnt[%0d]", k), 32'(dg[k]), 32'(eg));
      chk($sformatf("model_idx[%0d]", k), 32'(di[k]), 32'(ei));
      chk($sformatf("model_vld[%0d]", k), 32'(dv[k]), 32'(m[k].own >= 0));
      chk($sformatf("model_to[%0d]", k), 32'(dt[k]), 32'(m[k].to));
      chk($sformatf("onehot[%0d]", k), 32'($onehot0(dg[k])), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    req    = 8'hFF;
    step(2);
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_idx", 32'(idx_a), 32'h0);
    chk("rst_vld", 32'(vld_a), 32'h0);
    chk("rst_to",  32'(to_a),  32'h0);
    rst_n = 1'b1;
    step(1);
    chk("first_gnt", 32'(gnt_a), 32'h01);
    chk("first_idx", 32'(idx_a), 32'h0);

    // Rotation: each holder drops for one cycle, order 0..7 then 0 again.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rot_gnt%0d", i), 32'(gnt_a), 32'(8'b1 << (i % 8)));
      chk($sformatf("rot_idx%0d", i), 32'(idx_a), 32'(i % 8));
      req = ~(8'b1 << (i % 8));
      step(1);
      chk($sformatf("rot_gap%0d", i), 32'(gnt_a), 32'h0);
      req = 8'hFF;
      step(1);
    end
    req = 8'h00;
    step(2);

    // Single requester, three cycles.
    req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("single_gnt", 32'(gnt_a), 32'h04);
      chk("single_idx", 32'(idx_a), 32'h2);
    end
    req = 8'h00;
    step(1);
    chk("single_rel_gnt", 32'(gnt_a), 32'h0);
    chk("single_rel_vld", 32'(vld_a), 32'h0);
    chk("single_rel_to",  32'(to_a),  32'h0);
    step(1);

    // Bring ptr to 7, then MAX_HOLD=4 revocation on instance b.
    req = 8'h40;
    step(1);
    chk("ptr7_gnt", 32'(gnt_b), 32'h40);
    req = 8'h00;
    step(2);
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("hold_gnt%0d", i), 32'(gnt_b), 32'h80);
    end
    step(1);
    chk("tmo_gnt", 32'(gnt_b), 32'h0);
    chk("tmo_to",  32'(to_b),  32'h1);
    step(1);
    chk("tmo_next_gnt", 32'(gnt_b), 32'h01);
    chk("tmo_next_to",  32'(to_b),  32'h0);
    chk("long_hold_a",  32'(gnt_a), 32'h80);
    req = 8'h00;
    step(3);

    // Drop coincides with cnt==MAX_HOLD: plain release.
    req = 8'h08;
    step(4);
    chk("edge_gnt", 32'(gnt_b), 32'h08);
    req = 8'h00;
    step(1);
    chk("edge_rel_gnt", 32'(gnt_b), 32'h0);
    chk("edge_rel_to",  32'(to_b),  32'h0);
    step(2);

    // Enable gating.
    en  = 1'b0;
    req = 8'h10;
    step(2);
    chk("en_block", 32'(gnt_a), 32'h0);
    en = 1'b1;
    step(1);
    chk("en_grant", 32'(gnt_a), 32'h10);
    en = 1'b0;
    step(3);
    chk("en_hold", 32'(gnt_a), 32'h10);
    req = 8'h00;
    en  = 1'b1;
    step(2);

    // Asynchronous reset between edges while bit 5 owns the grant.
    req = 8'h20;
    step(1);
    chk("pre_rst_gnt", 32'(gnt_a), 32'h20);
    #1 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt_a), 32'h0);
    chk("async_vld", 32'(vld_a), 32'h0);
    #1 rst_n = 1'b1;
    step(1);
    chk("post_rst_gnt", 32'(gnt_a), 32'h20);
    chk("post_rst_idx", 32'(idx_a), 32'h5);
    req = 8'h00;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
